// File: rtl/ofdm_rx_pkg.sv
// ----------------------------------------------------------------------------
// ofdm_rx_pkg
// Shared definitions for the OFDM receive chain:
//   - cp_state_e : cyclic-prefix removal FSM states (IDLE, CP, DATA)
//   - DEF_*      : default frame geometry and sample width
//   - max_int / idx_width : constant helpers for sizing counters and ports
// ----------------------------------------------------------------------------
package ofdm_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_DATA = 2'd2
  } cp_state_e;

  localparam int DEF_FFT_LEN = 64;
  localparam int DEF_CP_LEN  = 16;
  localparam int DEF_SYM_NUM = 8;
  localparam int DEF_DW      = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of an index over n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cp_remove_if.sv
// ----------------------------------------------------------------------------
// cp_remove_if
// Sample-stream bundle around the cyclic-prefix remover.
//   i_valid/i_sync/i_re/i_im : time-synchronised input stream
//   o_valid/o_re/o_im        : useful samples (o_valid also enables the
//                              downstream per-symbol sample counter)
//   o_sop/o_eop/o_sym_idx    : symbol framing of the output stream
//   o_frame_done/o_busy/o_err: frame status
// Modports: master = stream source / sink side, slave = cp_remove.
// ----------------------------------------------------------------------------
interface cp_remove_if #(
  parameter int DW      = ofdm_rx_pkg::DEF_DW,
  parameter int SYM_NUM = ofdm_rx_pkg::DEF_SYM_NUM
);
  import ofdm_rx_pkg::*;

  localparam int IDX_W = idx_width(SYM_NUM);

  logic             i_valid;
  logic             i_sync;
  logic [DW-1:0]    i_re;
  logic [DW-1:0]    i_im;
  logic             o_valid;
  logic [DW-1:0]    o_re;
  logic [DW-1:0]    o_im;
  logic             o_sop;
  logic             o_eop;
  logic [IDX_W-1:0] o_sym_idx;
  logic             o_frame_done;
  logic             o_busy;
  logic             o_err;

  modport master (
    output i_valid, i_sync, i_re, i_im,
    input  o_valid, o_re, o_im, o_sop, o_eop, o_sym_idx,
    input  o_frame_done, o_busy, o_err
  );

  modport slave (
    input  i_valid, i_sync, i_re, i_im,
    output o_valid, o_re, o_im, o_sop, o_eop, o_sym_idx,
    output o_frame_done, o_busy, o_err
  );

endinterface

// File: rtl/sym_counter.sv
// ----------------------------------------------------------------------------
// sym_counter
// Enabled up-counter with a run-time terminal value.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count one event
//   clr        : restart the count; with en also high the current event is
//                the first one, so the count becomes 1 instead of 0
//   load_val   : terminal value; an enabled event at this value wraps to 0
//   cnt        : current count (registered)
//   last       : cnt equals the terminal value
// ----------------------------------------------------------------------------
module sym_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         last_s;

  assign last_s = (cnt_q == load_val);

  // Next count: clear has priority, the terminal value wraps to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      if (en) begin
        cnt_d = W'(1'b1);
      end else begin
        cnt_d = '0;
      end
    end else if (en) begin
      if (last_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = last_s;

endmodule

// File: rtl/cp_remove.sv
// ----------------------------------------------------------------------------
// cp_remove
// Drops the cyclic prefix of every OFDM symbol and forwards FFT_LEN useful
// samples per symbol with sop/eop framing and the symbol index. One-cycle
// latency from input sample to every output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cp_remove_if.slave (input stream in, useful stream out)
// A valid sync sample always starts a new frame as CP sample 0 of symbol 0;
// if a frame was still in progress it is abandoned and o_err pulses.
// ----------------------------------------------------------------------------
module cp_remove
  import ofdm_rx_pkg::*;
#(
  parameter int FFT_LEN = DEF_FFT_LEN,
  parameter int CP_LEN  = DEF_CP_LEN,
  parameter int SYM_NUM = DEF_SYM_NUM,
  parameter int DW      = DEF_DW
) (
  input  logic        clk,
  input  logic        rst_n,
  cp_remove_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(CP_LEN, FFT_LEN));
  localparam int IDX_W = idx_width(SYM_NUM);

  localparam logic [CNT_W-1:0] CP_TERM  = CNT_W'(CP_LEN - 1);
  localparam logic [CNT_W-1:0] FFT_TERM = CNT_W'(FFT_LEN - 1);
  localparam logic [IDX_W-1:0] SYM_TERM = IDX_W'(SYM_NUM - 1);

  cp_state_e        state_q;
  logic             busy_q;
  logic             valid_q;
  logic [DW-1:0]    re_q;
  logic [DW-1:0]    im_q;
  logic             sop_q;
  logic             eop_q;
  logic [IDX_W-1:0] idx_q;
  logic             done_q;
  logic             err_q;

  logic             start_s;
  logic             restart_s;
  logic             fwd_s;
  logic             eop_s;
  logic             sop_s;
  logic             done_s;
  logic             samp_en_s;
  logic             samp_clr_s;
  logic [CNT_W-1:0] samp_term_s;
  logic [CNT_W-1:0] samp_cnt_s;
  logic             samp_last_s;
  logic             sym_en_s;
  logic             sym_clr_s;
  logic [IDX_W-1:0] sym_cnt_s;
  logic             sym_last_s;

  // Control decode from the current state and the incoming sample.
  always_comb begin
    start_s     = bus.i_valid & bus.i_sync;
    restart_s   = start_s & (state_q != ST_IDLE);
    // A sync sample in DATA is a restart, never a forwarded sample.
    fwd_s       = bus.i_valid & ~bus.i_sync & (state_q == ST_DATA);
    eop_s       = fwd_s & samp_last_s;
    sop_s       = fwd_s & (samp_cnt_s == '0);
    done_s      = eop_s & sym_last_s;
    // Sync takes sample count to 1 through clr+en; otherwise count valid
    // samples only while a frame is active.
    samp_clr_s  = start_s;
    samp_en_s   = start_s | (bus.i_valid & (state_q != ST_IDLE));
    sym_clr_s   = start_s;
    sym_en_s    = eop_s;
    case (state_q)
      ST_CP:   samp_term_s = CP_TERM;
      ST_DATA: samp_term_s = FFT_TERM;
      default: samp_term_s = FFT_TERM;
    endcase
  end

  sym_counter #(.W(CNT_W)) u_samp_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (samp_en_s),
    .clr      (samp_clr_s),
    .load_val (samp_term_s),
    .cnt      (samp_cnt_s),
    .last     (samp_last_s)
  );

  sym_counter #(.W(IDX_W)) u_sym_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sym_en_s),
    .clr      (sym_clr_s),
    .load_val (SYM_TERM),
    .cnt      (sym_cnt_s),
    .last     (sym_last_s)
  );

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= fwd_s;
      sop_q   <= sop_s;
      eop_q   <= eop_s;
      done_q  <= done_s;
      err_q   <= restart_s;
      // Data and index hold their last forwarded values between samples.
      if (fwd_s) begin
        re_q  <= bus.i_re;
        im_q  <= bus.i_im;
        idx_q <= sym_cnt_s;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q <= ST_CP;
            busy_q  <= 1'b1;
          end
        end
        ST_CP: begin
          if (start_s) begin
            state_q <= ST_CP;
            busy_q  <= 1'b1;
          end else if (bus.i_valid & samp_last_s) begin
            state_q <= ST_DATA;
            busy_q  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (start_s) begin
            state_q <= ST_CP;
            busy_q  <= 1'b1;
          end else if (eop_s) begin
            if (sym_last_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_CP;
              busy_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_re         = re_q;
  assign bus.o_im         = im_q;
  assign bus.o_sop        = sop_q;
  assign bus.o_eop        = eop_q;
  assign bus.o_sym_idx    = idx_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_cp_remove.sv
// ----------------------------------------------------------------------------
// tb_cp_remove
// Directed, table-driven bench for cp_remove with FFT_LEN=64, CP_LEN=16,
// SYM_NUM=2. Each table record holds one input cycle and the outputs
// expected one clock later. Reset behaviour is exercised by hand-written
// sequences around the tables.
// ----------------------------------------------------------------------------
module tb_cp_remove;

  localparam int FFT_LEN   = 64;
  localparam int CP_LEN    = 16;
  localparam int SYM_NUM   = 2;
  localparam int DW        = 16;
  localparam int SYM_LEN   = FFT_LEN + CP_LEN;
  localparam int FRAME_LEN = SYM_LEN * SYM_NUM;

  typedef struct {
    logic          v;
    logic          s;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          ev;
    logic          esop;
    logic          eeop;
    logic          edone;
    logic          eerr;
    logic          ebusy;
    logic [0:0]    eidx;
    logic          cd;
    logic [DW-1:0] ere;
    logic [DW-1:0] eim;
    int            grp;
  } vec_t;

  logic clk;
  logic rst_n;

  vec_t          tbl[$];
  int            n_vec;
  int            n_bad;
  logic [DW-1:0] last_re;
  logic [DW-1:0] last_im;
  logic          busy_now;

  cp_remove_if #(.DW(DW), .SYM_NUM(SYM_NUM)) bus ();

  cp_remove #(
    .FFT_LEN (FFT_LEN),
    .CP_LEN  (CP_LEN),
    .SYM_NUM (SYM_NUM),
    .DW      (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame samples [first, first+count) of a frame whose ramp starts at base.
  task automatic add_samples(input int base, input int first, input int count,
                             input bit err_first, input bit gapped, input int grp);
    vec_t x;
    vec_t g;
    int   pos;
    int   sym;
    int   dpos;
    for (int k = first; k < first + count; k++) begin
      pos    = k % SYM_LEN;
      sym    = k / SYM_LEN;
      dpos   = pos - CP_LEN;
      x.v    = 1'b1;
      x.s    = (k == 0);
      x.re   = DW'(base + k);
      x.im   = DW'(base + k) ^ 16'h5A5A;
      x.ev   = (pos >= CP_LEN);
      x.esop = x.ev && (dpos == 0);
      x.eeop = x.ev && (dpos == FFT_LEN - 1);
      x.edone = x.eeop && (sym == SYM_NUM - 1);
      x.eerr = err_first && (k == first);
      x.ebusy = !x.edone;
      x.eidx = 1'(sym);
      if (x.ev) begin
        last_re = x.re;
        last_im = x.im;
      end
      x.cd   = 1'b1;
      x.ere  = last_re;
      x.eim  = last_im;
      x.grp  = grp;
      busy_now = x.ebusy;
      tbl.push_back(x);
      if (gapped) begin
        g       = x;
        g.v     = 1'b0;
        g.s     = (k % 2 == 1);
        g.re    = 16'hDEAD;
        g.im    = 16'hBEEF;
        g.ev    = 1'b0;
        g.esop  = 1'b0;
        g.eeop  = 1'b0;
        g.edone = 1'b0;
        g.eerr  = 1'b0;
        g.ebusy = busy_now;
        tbl.push_back(g);
      end
    end
  endtask

  task automatic add_idle(input int count, input int grp);
    vec_t x;
    for (int k = 0; k < count; k++) begin
      x.v     = 1'b1;
      x.s     = 1'b0;
      x.re    = DW'(16'h0F00 + k);
      x.im    = DW'(16'h0E00 + k);
      x.ev    = 1'b0;
      x.esop  = 1'b0;
      x.eeop  = 1'b0;
      x.edone = 1'b0;
      x.eerr  = 1'b0;
      x.ebusy = 1'b0;
      x.eidx  = 1'b0;
      x.cd    = 1'b1;
      x.ere   = last_re;
      x.eim   = last_im;
      x.grp   = grp;
      tbl.push_back(x);
    end
  endtask

  task automatic drive_idle();
    bus.i_valid = 1'b0;
    bus.i_sync  = 1'b0;
    bus.i_re    = '0;
    bus.i_im    = '0;
  endtask

  task automatic check_vec(input vec_t x, input int i);
    logic bad;
    bad = (bus.o_valid !== x.ev) || (bus.o_sop !== x.esop) || (bus.o_eop !== x.eeop) ||
          (bus.o_frame_done !== x.edone) || (bus.o_err !== x.eerr) || (bus.o_busy !== x.ebusy) ||
          (x.ev && (bus.o_sym_idx !== x.eidx)) ||
          (x.cd && ((bus.o_re !== x.ere) || (bus.o_im !== x.eim)));
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL vec%0d grp%0d: got v=%b sop=%b eop=%b idx=%0d done=%b err=%b busy=%b re=%h im=%h, expected v=%b sop=%b eop=%b idx=%0d done=%b err=%b busy=%b re=%h im=%h",
               i, x.grp, bus.o_valid, bus.o_sop, bus.o_eop, bus.o_sym_idx, bus.o_frame_done,
               bus.o_err, bus.o_busy, bus.o_re, bus.o_im, x.ev, x.esop, x.eeop, x.eidx,
               x.edone, x.eerr, x.ebusy, x.ere, x.eim);
    end
  endtask

  // Called just after a falling edge: drive, let one rising edge pass, check.
  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      bus.i_valid = tbl[i].v;
      bus.i_sync  = tbl[i].s;
      bus.i_re    = tbl[i].re;
      bus.i_im    = tbl[i].im;
      @(negedge clk);
      check_vec(tbl[i], i);
    end
    tbl.delete();
    drive_idle();
  endtask

  task automatic check_zero(input string name);
    logic bad;
    bad = (bus.o_valid !== 1'b0) || (bus.o_sop !== 1'b0) || (bus.o_eop !== 1'b0) ||
          (bus.o_frame_done !== 1'b0) || (bus.o_err !== 1'b0) || (bus.o_busy !== 1'b0) ||
          (bus.o_sym_idx !== 1'b0) || (bus.o_re !== 16'h0000) || (bus.o_im !== 16'h0000);
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got v=%b sop=%b eop=%b idx=%0d done=%b err=%b busy=%b re=%h im=%h, expected all zero",
               name, bus.o_valid, bus.o_sop, bus.o_eop, bus.o_sym_idx, bus.o_frame_done,
               bus.o_err, bus.o_busy, bus.o_re, bus.o_im);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    last_re  = '0;
    last_im  = '0;
    busy_now = 1'b0;
    rst_n    = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal frame, continuous valid, ramp 0..159.
    add_samples(0, 0, FRAME_LEN, 1'b0, 1'b0, 1);
    // Valid samples without sync while idle: nothing forwarded, data held.
    add_idle(8, 2);
    // Same ramp with a bubble after every sample; bubbles carry a stray sync.
    add_samples(0, 0, FRAME_LEN, 1'b0, 1'b1, 3);
    // Restart at DATA count 30 of symbol 0, then a full frame from the restart.
    add_samples(16'h2000, 0, CP_LEN + 30, 1'b0, 1'b0, 4);
    add_samples(16'h3000, 0, FRAME_LEN, 1'b1, 1'b0, 4);
    // Back-to-back: next frame syncs on the sample right after frame_done.
    add_samples(16'h4000, 0, FRAME_LEN, 1'b0, 1'b0, 5);
    run_table();

    // Reset mid-symbol: run to DATA count 9, then pull reset with count 10 applied.
    add_samples(16'h5000, 0, CP_LEN + 10, 1'b0, 1'b0, 6);
    run_table();
    bus.i_valid = 1'b1;
    bus.i_sync  = 1'b0;
    bus.i_re    = DW'(16'h5000 + CP_LEN + 10);
    bus.i_im    = DW'(16'h5000 + CP_LEN + 10) ^ 16'h5A5A;
    rst_n       = 1'b0;
    #1;
    check_zero("reset_async");
    @(negedge clk);
    check_zero("reset_held");
    drive_idle();
    rst_n   = 1'b1;
    last_re = '0;
    last_im = '0;
    @(negedge clk);
    add_samples(16'h6000, 0, FRAME_LEN, 1'b0, 1'b0, 7);
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cp_remove.md
Name: cp_remove

Overview:
- RX OFDM stage placed directly after timing sync and before the FFT sample-index counter and FFT core.
- Takes the continuous I/Q sample stream plus a frame-start pulse.
- Discards the cyclic prefix of every symbol and forwards exactly FFT_LEN samples per symbol, marked with start/end flags and a symbol index.
- Generates the enable stream that drives the downstream per-symbol sample counter.

Parameters:
- FFT_LEN, 64: useful samples per symbol; power of two, ≥4.
- CP_LEN, 16: cyclic-prefix samples per symbol; ≥2.
- SYM_NUM, 8: OFDM symbols per frame; ≥1.
- DW, 16: width of each of I and Q, two's complement.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- i_valid  in  1  input sample qualifier.
- i_sync  in  1  frame start; meaningful only with i_valid; marks CP sample 0 of symbol 0.
- i_re  in  DW  input I.
- i_im  in  DW  input Q.
- o_valid  out  1  output sample valid; also the downstream counter enable.
- o_re  out  DW  output I.
- o_im  out  DW  output Q.
- o_sop  out  1  first useful sample of a symbol.
- o_eop  out  1  last useful sample of a symbol.
- o_sym_idx  out  $clog2(SYM_NUM) (min 1)  symbol index within the frame.
- o_frame_done  out  1  one-cycle pulse coincident with the eop of symbol SYM_NUM-1.
- o_busy  out  1  high while the FSM is not in IDLE.
- o_err  out  1  one-cycle pulse when a frame is restarted before it completes.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, sample counter 0, symbol counter 0.
- FSM states:
  - IDLE:
    - i_valid & i_sync: sample is CP index 0; go to CP with sample count 1; symbol index 0.
    - Otherwise: drop the sample.
  - CP:
    - Each valid sample is dropped and increments the sample count.
    - Valid sample at count CP_LEN-1: go to DATA, count cleared to 0.
  - DATA:
    - Each valid sample is forwarded; count increments.
    - Valid sample at count FFT_LEN-1 is the eop sample.
    - After eop: if symbol index = SYM_NUM-1, go to IDLE, index 0, o_frame_done pulses with the eop. Otherwise go to CP, index+1, count 0.
- Cycles with i_valid=0: no state change, counters hold, o_valid=0.
- Datapath: all outputs registered; latency exactly 1 clk from input sample to o_valid/o_re/o_im/o_sop/o_eop/o_sym_idx.
- o_sop is asserted at DATA count 0; o_eop at DATA count FFT_LEN-1. o_re/o_im hold their last values when o_valid=0.
- o_sym_idx is valid whenever o_valid=1; it equals the index of the symbol being forwarded.
- Per frame, o_valid is high for exactly SYM_NUM×FFT_LEN samples.
- Restart (i_valid & i_sync in CP or DATA):
  - The current frame is aborted with no o_eop or o_frame_done issued.
  - o_err pulses one cycle later, with the same timing as the output registers.
  - The sample is treated as CP index 0 of a new symbol 0: state CP, count 1.
- i_sync with i_valid=0 is ignored in all states.
- Counter widths:
  - Sample counter is $clog2(max(CP_LEN,FFT_LEN)) bits.
  - Comparisons are made against CP_LEN-1 and FFT_LEN-1 only; no wrap beyond the terminal values.
- Asserting rst_n low mid-frame clears everything immediately; no partial outputs appear after reset.

Decomposition:
- Shared package ofdm_rx_pkg:
  - FSM state enum (IDLE, CP, DATA).
  - Default FFT_LEN, CP_LEN, SYM_NUM, DW constants.
- One sub-module: sym_counter, a generic enabled terminal-count counter.
  - Ports: clk, rst_n, en, clr, load_val, cnt, last.
  - Instantiated twice: for the sample count (terminal value switched by state) and for the symbol index.

Test Plan:
- Nominal frame (FFT_LEN=64, CP_LEN=16, SYM_NUM=2), continuous valid, sync on sample 0, ramp input 0..159 → o_valid for input values 16..79 and 96..159. o_sop on 16 and 96; o_eop on 79 and 159; o_sym_idx 0 then 1. o_frame_done on 159. Latency 1 clk.
- Gapped valid: i_valid toggles 1/0 over the same ramp → identical output sequence, o_valid only on cycles following valid inputs, counters frozen during gaps.
- Restart: second i_sync at DATA count 30 of symbol 0 → o_err pulses once, no eop issued. The next 16 samples are dropped and the following 64 are output with o_sop and o_sym_idx=0.
- Idle noise: valid samples with no sync → o_valid, o_busy, o_frame_done all stay 0.
- Reset mid-symbol: rst_n low at DATA count 10 → all outputs 0 next edge. After release, a fresh sync yields a correct full frame.
- Back-to-back frames: sync on the sample immediately after frame_done → the second frame is forwarded correctly, with no o_err.
